// File: rtl/compare_arbiter_if.sv
// Handshake bundle between requesters and the shared comparator.
// Requester side drives operands and result back-pressure.
interface compare_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [ID_W-1:0]          res_id;
  logic                     res_gt;
  logic                     res_lt;
  logic                     res_eq;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id,
    input  res_gt, res_lt, res_eq, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id,
    output res_gt, res_lt, res_eq, busy
  );
endinterface

// File: rtl/compare_arbiter.sv
// One unsigned comparator shared round-robin between NUM_REQ requesters.
// IDLE grants and latches a pair, CMP compares, RESULT holds until taken.
module compare_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  compare_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESULT
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               eq_q, eq_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               found;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin : rr_scan
    logic [ID_W-1:0] idx;
    idx    = '0;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    res_id_d = res_id_q;
    a_d      = a_q;
    b_d      = b_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = bus.req_a[gnt_id*WIDTH +: WIDTH];
          b_d     = bus.req_b[gnt_id*WIDTH +: WIDTH];
          id_d    = gnt_id;
          state_d = CMP;
          if (gnt_id == ID_W'(NUM_REQ - 1))
            ptr_d = '0;
          else
            ptr_d = gnt_id + 1'b1;
        end
      end
      CMP: begin
        gt_d     = (a_q > b_q);
        lt_d     = (a_q < b_q);
        eq_d     = (a_q == b_q);
        res_id_d = id_q;
        state_d  = RESULT;
      end
      RESULT: begin
        if (bus.res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      res_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      res_id_q <= res_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.res_valid = (state_q == RESULT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_id    = res_id_q;
  assign bus.res_gt    = gt_q;
  assign bus.res_lt    = lt_q;
  assign bus.res_eq    = eq_q;

endmodule
